// File: rtl/pwm_shadow_update_ctrl.sv
// ============================================================================
// Module   : pwm_shadow_update_ctrl
// Purpose  : Stages PWM shadow-register values and issues a single coherent
//            load strobe on an eligible carrier event after a software commit.
//            Optional event prescaler is enabled with PWM_UPD_PRESCALE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_shadow_update_ctrl #(
  parameter int NREG  = 4,
  parameter int DW    = 16,
  parameter int PSC_W = 8,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 commit,
  input  logic                 abort,
  input  logic [1:0]           upd_mode,
  input  logic                 evt_zero,
  input  logic                 evt_peak,
`ifdef PWM_UPD_PRESCALE_EN
  input  logic [PSC_W-1:0]     upd_psc,
`endif
  output logic [NREG*DW-1:0]   stage_out,
  output logic                 mask_event,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [1:0] c_mode_zero = 2'b00;
  localparam logic [1:0] c_mode_peak = 2'b01;
  localparam logic [1:0] c_mode_any  = 2'b10;
  localparam logic [1:0] c_mode_imm  = 2'b11;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_mode;
  logic              r_mask_event;
  logic              r_busy;
  logic [DW-1:0]     r_stage [NREG];
  logic              w_wr_fire;
  logic              w_evt;
  logic              w_psc_done;

  assign w_wr_fire = wr_valid & wr_ready;

  // Simultaneous zero and peak pulses collapse into a single event.
  always_comb begin
    w_evt = 1'b0;
    case (r_mode)
      c_mode_zero: w_evt = evt_zero;
      c_mode_peak: w_evt = evt_peak;
      c_mode_any:  w_evt = evt_zero | evt_peak;
      default:     w_evt = 1'b0;
    endcase
  end

`ifdef PWM_UPD_PRESCALE_EN
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_evt_cnt;

  assign w_psc_done = (r_evt_cnt == r_psc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_psc     <= '0;
      r_evt_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (commit) begin
            r_psc     <= upd_psc;
            r_evt_cnt <= '0;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            r_evt_cnt <= '0;
          end else if (w_evt && !w_psc_done) begin
            r_evt_cnt <= r_evt_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign w_psc_done = 1'b1;

  // The prescaler width only matters when the prescaler is built in.
  if (PSC_W < 1) begin : g_psc_w_unused
  end
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (commit) begin
          w_next_state = (upd_mode == c_mode_imm) ? ST_LOAD : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          w_next_state = ST_IDLE;
        end else if (w_evt && w_psc_done) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= c_mode_zero;
      r_mask_event <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_mask_event <= (w_next_state == ST_LOAD);
      r_busy       <= (w_next_state != ST_IDLE);
      if (r_state == ST_IDLE && commit) begin
        r_mode <= upd_mode;
      end
    end
  end

  // Staging writes only land while idle; out-of-range indices are swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_stage[i] <= '0;
      end
    end else if (w_wr_fire && (32'(wr_addr) < NREG)) begin
      r_stage[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_stage_out
    assign stage_out[gi*DW +: DW] = r_stage[gi];
  end

  assign wr_ready   = (r_state == ST_IDLE);
  assign mask_event = r_mask_event;
  assign busy       = r_busy;

endmodule

`default_nettype wire
